// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled one-second ticks drive cascaded sec/min/hrs fields,
// with validated load, tick-driven alarm, day-wrap pulse and a 12/24-hour display view.
module tod_counter #(
   parameter int TICK_DIV = 50000000,
   parameter int SEC_MAX  = 59,
   parameter int MIN_MAX  = 59,
   parameter int HRS_MAX  = 23,
   parameter int CNT_W    = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_en,
   input  logic             io_set,
   input  logic [CNT_W-1:0] io_set_sec,
   input  logic [CNT_W-1:0] io_set_min,
   input  logic [CNT_W-1:0] io_set_hrs,
   input  logic             io_alarm_en,
   input  logic [CNT_W-1:0] io_alarm_sec,
   input  logic [CNT_W-1:0] io_alarm_min,
   input  logic [CNT_W-1:0] io_alarm_hrs,
   input  logic             io_mode12,
   output logic [CNT_W-1:0] io_sec,
   output logic [CNT_W-1:0] io_min,
   output logic [CNT_W-1:0] io_hrs,
   output logic [CNT_W-1:0] io_hrs_disp,
   output logic             io_pm,
   output logic             io_tick,
   output logic             io_day_wrap,
   output logic             io_alarm,
   output logic             io_set_err
);

   localparam int               P_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [P_W-1:0]   P_LAST   = P_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(SEC_MAX);
   localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_MAX);
   localparam logic [CNT_W-1:0] HRS_LAST = CNT_W'(HRS_MAX);
   localparam logic [CNT_W-1:0] TWELVE   = CNT_W'(12);

   logic [P_W-1:0]   p;
   logic             set_ok;
   logic             set_bad;
   logic             tick_now;
   logic             sec_wrap;
   logic             min_wrap;
   logic             hrs_wrap;
   logic [CNT_W-1:0] sec_nxt;
   logic [CNT_W-1:0] min_nxt;
   logic [CNT_W-1:0] hrs_nxt;

   // A valid load wins over a coincident tick, so the tick is suppressed here.
   always_comb begin
      set_ok   = io_set && (io_set_sec <= SEC_LAST) && (io_set_min <= MIN_LAST)
                        && (io_set_hrs <= HRS_LAST);
      set_bad  = io_set && !set_ok;
      tick_now = io_en && (p == P_LAST) && !set_ok;
      sec_wrap = (io_sec == SEC_LAST);
      min_wrap = sec_wrap && (io_min == MIN_LAST);
      hrs_wrap = min_wrap && (io_hrs == HRS_LAST);
      sec_nxt  = sec_wrap ? '0 : io_sec + CNT_W'(1);
      min_nxt  = min_wrap ? '0 : (sec_wrap ? io_min + CNT_W'(1) : io_min);
      hrs_nxt  = hrs_wrap ? '0 : (min_wrap ? io_hrs + CNT_W'(1) : io_hrs);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p <= '0;
      end else if (set_ok) begin
         p <= '0;
      end else if (io_en) begin
         p <= (p == P_LAST) ? '0 : p + P_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_sec <= '0;
         io_min <= '0;
         io_hrs <= '0;
      end else if (set_ok) begin
         io_sec <= io_set_sec;
         io_min <= io_set_min;
         io_hrs <= io_set_hrs;
      end else if (tick_now) begin
         io_sec <= sec_nxt;
         io_min <= min_nxt;
         io_hrs <= hrs_nxt;
      end
   end

   // Pulses register on the same edge as the time update they describe.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_tick     <= 1'b0;
         io_day_wrap <= 1'b0;
         io_alarm    <= 1'b0;
         io_set_err  <= 1'b0;
      end else begin
         io_tick     <= tick_now;
         io_day_wrap <= tick_now && hrs_wrap;
         io_alarm    <= tick_now && io_alarm_en && (sec_nxt == io_alarm_sec)
                        && (min_nxt == io_alarm_min) && (hrs_nxt == io_alarm_hrs);
         io_set_err  <= set_bad;
      end
   end

   always_comb begin
      io_hrs_disp = io_hrs;
      io_pm       = 1'b0;
      if (io_mode12) begin
         if (io_hrs == '0) begin
            io_hrs_disp = TWELVE;
         end else if (io_hrs > TWELVE) begin
            io_hrs_disp = io_hrs - TWELVE;
            io_pm       = 1'b1;
         end else if (io_hrs == TWELVE) begin
            io_pm       = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tod_counter.sv
// Scoreboard bench for tod_counter: a seconds-of-day model pushes expected outputs per
// driven cycle, which are popped and compared once the DUT edge has produced them.
module tb_tod_counter;

   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 6;
   localparam int DAY      = 24 * 60 * 60;

   typedef struct {
      string tag;
      int    val;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             io_en = 1'b0;
   logic             io_set = 1'b0;
   logic [CNT_W-1:0] io_set_sec = '0;
   logic [CNT_W-1:0] io_set_min = '0;
   logic [CNT_W-1:0] io_set_hrs = '0;
   logic             io_alarm_en = 1'b0;
   logic [CNT_W-1:0] io_alarm_sec = '0;
   logic [CNT_W-1:0] io_alarm_min = '0;
   logic [CNT_W-1:0] io_alarm_hrs = '0;
   logic             io_mode12 = 1'b0;
   logic [CNT_W-1:0] io_sec;
   logic [CNT_W-1:0] io_min;
   logic [CNT_W-1:0] io_hrs;
   logic [CNT_W-1:0] io_hrs_disp;
   logic             io_pm;
   logic             io_tick;
   logic             io_day_wrap;
   logic             io_alarm;
   logic             io_set_err;

   int   errCount   = 0;
   int   checkCount = 0;
   int   tbTod      = 0;
   int   tbPc       = 0;
   exp_t expQ[$];

   int   hrsList[5]  = '{0, 11, 12, 13, 23};
   int   dispList[5] = '{12, 11, 12, 1, 11};
   int   pmList[5]   = '{0, 0, 1, 1, 1};

   tod_counter #(.TICK_DIV(TICK_DIV), .SEC_MAX(59), .MIN_MAX(59), .HRS_MAX(23), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .io_en(io_en), .io_set(io_set),
      .io_set_sec(io_set_sec), .io_set_min(io_set_min), .io_set_hrs(io_set_hrs),
      .io_alarm_en(io_alarm_en), .io_alarm_sec(io_alarm_sec), .io_alarm_min(io_alarm_min),
      .io_alarm_hrs(io_alarm_hrs), .io_mode12(io_mode12),
      .io_sec(io_sec), .io_min(io_min), .io_hrs(io_hrs), .io_hrs_disp(io_hrs_disp),
      .io_pm(io_pm), .io_tick(io_tick), .io_day_wrap(io_day_wrap), .io_alarm(io_alarm),
      .io_set_err(io_set_err)
   );

   always #5 clock = ~clock;

   function automatic int packOut(int h, int m, int s, int tk, int wr, int al, int er);
      return (h << 22) | (m << 16) | (s << 10) | (tk << 3) | (wr << 2) | (al << 1) | er;
   endfunction

   function automatic int dutOut();
      return packOut(int'(io_hrs), int'(io_min), int'(io_sec), int'(io_tick),
                     int'(io_day_wrap), int'(io_alarm), int'(io_set_err));
   endfunction

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Model steps one cycle on the current inputs and queues the outputs the edge must yield.
   task automatic pushExpected(input string tag);
      int   tk = 0, wr = 0, al = 0, er = 0;
      bit   loaded = 0;
      exp_t e;
      if (io_set) begin
         if (io_set_sec <= 59 && io_set_min <= 59 && io_set_hrs <= 23) begin
            tbTod  = int'(io_set_hrs) * 3600 + int'(io_set_min) * 60 + int'(io_set_sec);
            tbPc   = 0;
            loaded = 1;
         end else begin
            er = 1;
         end
      end
      if (!loaded && io_en) begin
         if (tbPc == TICK_DIV - 1) begin
            tbPc  = 0;
            tbTod = (tbTod + 1) % DAY;
            tk    = 1;
            wr    = (tbTod == 0) ? 1 : 0;
            al    = (io_alarm_en && tbTod == int'(io_alarm_hrs) * 3600 + int'(io_alarm_min) * 60
                     + int'(io_alarm_sec)) ? 1 : 0;
         end else begin
            tbPc++;
         end
      end
      e.tag = tag;
      e.val = packOut(tbTod / 3600, (tbTod / 60) % 60, tbTod % 60, tk, wr, al, er);
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input string tag, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         pushExpected($sformatf("%s[%0d]", tag, i));
         @(posedge clock);
         #1;
         e = expQ.pop_front();
         checkOutput(e.tag, dutOut(), e.val);
      end
   endtask

   task automatic loadTime(input string tag, input int h, input int m, input int s);
      io_set_hrs = CNT_W'(h);
      io_set_min = CNT_W'(m);
      io_set_sec = CNT_W'(s);
      io_set     = 1'b1;
      applyStimulus(tag, 1);
      io_set     = 1'b0;
   endtask

   initial begin
      io_mode12 = 1'b1;
      #3;
      checkOutput("reset_state", dutOut(), 0);
      checkOutput("reset_disp12", int'(io_hrs_disp), 12);
      checkOutput("reset_pm12", int'(io_pm), 0);
      io_mode12 = 1'b0;
      #1;
      checkOutput("reset_disp24", int'(io_hrs_disp), 0);
      @(negedge clock);
      reset = 1'b1;

      io_en = 1'b1;
      applyStimulus("run60", TICK_DIV * 60 + 2);
      checkOutput("run60_min", int'(io_min), 1);

      loadTime("load_235959", 23, 59, 59);
      applyStimulus("day_wrap", TICK_DIV + 2);

      loadTime("load_bad", 0, 60, 0);
      applyStimulus("after_bad", 1);
      while (tbPc != TICK_DIV - 1) applyStimulus("align", 1);
      loadTime("load_coincident", 12, 30, 15);
      applyStimulus("after_load", TICK_DIV + 1);
      checkOutput("after_load_sec", int'(io_sec), 16);

      io_alarm_hrs = 6'd1;
      io_alarm_min = 6'd0;
      io_alarm_sec = 6'd0;
      io_alarm_en  = 1'b1;
      loadTime("alarm_load", 0, 59, 58);
      applyStimulus("alarm_on", TICK_DIV * 3);
      io_alarm_en  = 1'b0;
      loadTime("alarm_load_off", 0, 59, 58);
      applyStimulus("alarm_off", TICK_DIV * 3);
      io_alarm_en  = 1'b1;
      loadTime("alarm_direct", 1, 0, 0);
      applyStimulus("alarm_direct_run", 2);

      io_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         loadTime("disp_load", hrsList[i], 0, 0);
         io_mode12 = 1'b1;
         #1;
         checkOutput($sformatf("disp12_h%0d", hrsList[i]), int'(io_hrs_disp), dispList[i]);
         checkOutput($sformatf("pm12_h%0d", hrsList[i]), int'(io_pm), pmList[i]);
         io_mode12 = 1'b0;
         #1;
         checkOutput($sformatf("disp24_h%0d", hrsList[i]), int'(io_hrs_disp), hrsList[i]);
         checkOutput($sformatf("pm24_h%0d", hrsList[i]), int'(io_pm), 0);
      end

      io_en = 1'b1;
      applyStimulus("pre_hold", 2);
      io_en = 1'b0;
      applyStimulus("hold", 10);
      io_en = 1'b1;
      applyStimulus("resume", TICK_DIV * 2);

      applyStimulus("pre_reset", 3);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset", dutOut(), 0);
      tbTod = 0;
      tbPc  = 0;
      @(posedge clock);
      #1;
      checkOutput("reset_held", dutOut(), 0);
      @(negedge clock);
      reset = 1'b1;
      applyStimulus("post_reset", TICK_DIV + 2);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tod_counter.md
# tod_counter

Parametrised time-of-day counter: a prescaler divides the system clock into one-second ticks that drive cascaded seconds/minutes/hours counters with configurable wrap limits. It adds run enable, validated time load, an alarm comparator, a 12/24-hour display view and day-wrap indication. It sits beside the control/status logic as the timekeeping source for display and event blocks.

## Interface
Parameters:
- TICK_DIV, 50000000, clock cycles per second tick (≥2)
- SEC_MAX, 59, last seconds value before wrap
- MIN_MAX, 59, last minutes value before wrap
- HRS_MAX, 23, last hours value before wrap
- CNT_W, 6, width of each time field (must hold SEC_MAX, MIN_MAX, HRS_MAX)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- io_en  in  1  run enable; low freezes prescaler and counters
- io_set  in  1  single-cycle load strobe
- io_set_sec / io_set_min / io_set_hrs  in  CNT_W  load values
- io_alarm_en  in  1  alarm enable
- io_alarm_sec / io_alarm_min / io_alarm_hrs  in  CNT_W  alarm time, sampled every cycle
- io_mode12  in  1  1 = 12-hour display view
- io_sec / io_min / io_hrs  out  CNT_W  current time, 24-hour form (registered)
- io_hrs_disp  out  CNT_W  display hours (combinational from io_hrs, io_mode12)
- io_pm  out  1  PM flag in 12-hour view, else 0
- io_tick  out  1  one-cycle pulse, time advanced
- io_day_wrap  out  1  one-cycle pulse, all three fields wrapped to 0
- io_alarm  out  1  one-cycle pulse on alarm match
- io_set_err  out  1  one-cycle pulse, load rejected

## Operation
- Prescaler p counts 0..TICK_DIV-1 while io_en=1; holds when io_en=0. Tick condition: io_en=1 and p=TICK_DIV-1; p then wraps to 0.
- On tick: sec+1; if sec=SEC_MAX, sec←0 and min+1; if also min=MIN_MAX, min←0 and hrs+1; if also hrs=HRS_MAX, hrs←0 and io_day_wrap fires.
- Load: io_set=1 with io_set_sec≤SEC_MAX, io_set_min≤MIN_MAX, io_set_hrs≤HRS_MAX → fields loaded, p←0, no tick/alarm/day_wrap that cycle. Any field out of range → no state change (p keeps counting), io_set_err pulses.
- Load has priority over a coincident tick; that tick is discarded (io_tick stays 0).
- io_set is honoured regardless of io_en.
- Alarm: fires only on tick-driven updates, when io_alarm_en=1 and new (sec,min,hrs) equals alarm inputs. A load to the alarm time does not fire.
- Display: io_mode12=0 → io_hrs_disp=io_hrs, io_pm=0. io_mode12=1 (meaningful only for HRS_MAX=23): hrs 0→12/AM, 1..11→same/AM, 12→12/PM, 13..23→hrs-12/PM.
- Field arithmetic in CNT_W bits; no value beyond its MAX is ever stored.

## Timing
- Reset (reset=0, asynchronous): p=0, io_sec=io_min=io_hrs=0, io_tick=io_day_wrap=io_alarm=io_set_err=0. io_hrs_disp/io_pm follow io_mode12 (12 with io_pm=0 in 12-hour view). Release synchronous to clock.
- First tick after reset or load: TICK_DIV cycles of io_en=1 after release/load edge.
- Counter update and pulses register on the same edge: io_tick, io_day_wrap, io_alarm high in the cycle where new time is visible, for exactly one cycle.
- io_set_err high in the cycle after the rejecting edge, one cycle.
- Loaded values visible the cycle after the io_set edge.
- io_en drop mid-count: p holds value; resumes on next io_en=1 without reset of p.
- Reset asserted mid-operation: all state cleared immediately, pending pulses dropped.

## Test plan
- TICK_DIV=4, defaults: release reset, io_en=1 → io_tick every 4th cycle, io_sec 0→1→2…; after 60 ticks io_sec=0, io_min=1.
- Load 23:59:59, run one tick → io_sec=io_min=io_hrs=0, io_tick=1 and io_day_wrap=1 same cycle, one cycle only.
- Load 00:60:00 → io_set_err pulses once, time unchanged; load 12:30:15 with coincident tick → 12:30:15, io_tick=0, next tick after 4 cycles gives 12:30:16.
- Alarm 01:00:00, io_alarm_en=1, load 00:59:58 → io_alarm pulses on second tick only; repeat with io_alarm_en=0 → no pulse; load 01:00:00 directly → no pulse.
- io_mode12=1 at hrs 0, 11, 12, 13, 23 → disp/pm 12/0, 11/0, 12/1, 1/1, 11/1; io_mode12=0 → disp=hrs, pm=0.
- Toggle io_en low for 10 cycles mid-prescale, then assert reset=0 mid-run → time frozen while low, tick phase preserved; reset clears all outputs asynchronously.
